// File: rtl/exec_alu_stage_pkg.sv
// exec_alu_stage_pkg: AAP execute-stage opcode numbering and opcode classification helpers.
package exec_alu_stage_pkg;

    localparam int OP_ADD  = 1;
    localparam int OP_SUB  = 2;
    localparam int OP_AND  = 3;
    localparam int OP_OR   = 4;
    localparam int OP_XOR  = 5;
    localparam int OP_ASR  = 6;
    localparam int OP_LSL  = 7;
    localparam int OP_LSR  = 8;
    localparam int OP_MOV  = 9;
    localparam int OP_ADDI = 10;
    localparam int OP_SUBI = 11;
    localparam int OP_ASRI = 12;
    localparam int OP_LSLI = 13;
    localparam int OP_LSRI = 14;
    localparam int OP_MOVI = 15;
    localparam int OP_BEQ  = 34;
    localparam int OP_BNE  = 35;
    localparam int OP_BLT  = 36;
    localparam int OP_BGT  = 37;
    localparam int OP_BLTU = 38;
    localparam int OP_BGTU = 39;

    // immediate bit that turns add/sub into adc/sbc
    localparam int ADC_SEL_BIT = 0;

    typedef enum logic [1:0] {KIND_NONE, KIND_ALU, KIND_CMP} op_kind_e;

    function automatic op_kind_e op_kind(input int op);
        return (op >= OP_ADD && op <= OP_MOVI) ? KIND_ALU :
               (op >= OP_BEQ && op <= OP_BGTU) ? KIND_CMP : KIND_NONE;
    endfunction

    function automatic logic uses_imm(input int op);
        return op >= OP_ADDI && op <= OP_MOVI;
    endfunction

endpackage

// File: rtl/exec_alu_stage_skid_buf.sv
// exec_alu_stage_skid_buf: 2-entry in-order result buffer with push/pop/flush and registered not_full.
module exec_alu_stage_skid_buf #(
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] push_data,
    output logic          out_valid,
    output logic [DW-1:0] head_data,
    output logic          not_full
);

    logic [1:0]    count_q, count_d;
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic          not_full_q, not_full_d;

    // a push lands in the head slot whenever the head is empty or leaving this cycle
    always_comb begin
        count_d    = flush ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
        head_d     = (pop && count_q == 2'd2) ? tail_q :
                     (push && (count_q == 2'd0 || pop)) ? push_data : head_q;
        tail_d     = (push && !pop && count_q == 2'd1) ? push_data : tail_q;
        not_full_d = count_d != 2'd2;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q    <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
            not_full_q <= 1'b1;
        end else begin
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            not_full_q <= not_full_d;
        end
    end

    assign out_valid = count_q != 2'd0;
    assign head_data = head_q;
    assign not_full  = not_full_q;

endmodule

// File: rtl/exec_alu_stage.sv
// exec_alu_stage: AAP execute stage -- ALU, immediate ALU, carry flag and branch compare,
// with a valid/ready handshake into a 2-entry result buffer and a flush input.
module exec_alu_stage
    import exec_alu_stage_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int REG_ADDR_W = 6,
    parameter int OP_W       = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_W-1:0]       in_op,
    input  logic [REG_ADDR_W-1:0] in_dest,
    input  logic [WIDTH-1:0]      in_a,
    input  logic [WIDTH-1:0]      in_b,
    input  logic [WIDTH-1:0]      in_imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_ADDR_W-1:0] out_dest,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_wr_en,
    output logic                  out_br_taken,
    output logic                  carry
);

    localparam int DW = REG_ADDR_W + WIDTH + 2;

    op_kind_e        kind;
    logic [WIDTH-1:0] opnd, alu_res, res_data;
    logic [WIDTH:0]   sum, diff;
    logic             cin, cmp, carry_upd, carry_new, accept;
    logic             carry_q, carry_d;
    logic [DW-1:0]    push_data, head_data;

    always_comb begin
        kind = op_kind(int'(in_op));
        opnd = uses_imm(int'(in_op)) ? in_imm : in_b;
        cin  = (in_op == OP_W'(OP_ADD) || in_op == OP_W'(OP_SUB)) & in_imm[ADC_SEL_BIT] & carry_q;
        sum  = {1'b0, in_a} + {1'b0, opnd} + {{WIDTH{1'b0}}, cin};
        // bit WIDTH of the extended difference is the borrow of a - (b + cin)
        diff = {1'b0, in_a} - {1'b0, opnd} - {{WIDTH{1'b0}}, cin};
        case (in_op)
            OP_W'(OP_ADD), OP_W'(OP_ADDI): alu_res = sum[WIDTH-1:0];
            OP_W'(OP_SUB), OP_W'(OP_SUBI): alu_res = diff[WIDTH-1:0];
            OP_W'(OP_AND):                 alu_res = in_a & in_b;
            OP_W'(OP_OR):                  alu_res = in_a | in_b;
            OP_W'(OP_XOR):                 alu_res = in_a ^ in_b;
            OP_W'(OP_ASR), OP_W'(OP_ASRI): alu_res = $signed(in_a) >>> opnd;
            OP_W'(OP_LSL), OP_W'(OP_LSLI): alu_res = in_a << opnd;
            OP_W'(OP_LSR), OP_W'(OP_LSRI): alu_res = in_a >> opnd;
            OP_W'(OP_MOV):                 alu_res = in_a;
            OP_W'(OP_MOVI):                alu_res = in_imm;
            default:                       alu_res = '0;
        endcase
        case (in_op)
            OP_W'(OP_BEQ):  cmp = in_a == in_b;
            OP_W'(OP_BNE):  cmp = in_a != in_b;
            OP_W'(OP_BLT):  cmp = $signed(in_a) < $signed(in_b);
            OP_W'(OP_BGT):  cmp = $signed(in_a) > $signed(in_b);
            OP_W'(OP_BLTU): cmp = in_a < in_b;
            OP_W'(OP_BGTU): cmp = in_a > in_b;
            default:        cmp = 1'b0;
        endcase
        carry_upd = in_op == OP_W'(OP_ADD) || in_op == OP_W'(OP_ADDI) ||
                    in_op == OP_W'(OP_SUB) || in_op == OP_W'(OP_SUBI);
        carry_new = (in_op == OP_W'(OP_SUB) || in_op == OP_W'(OP_SUBI)) ? diff[WIDTH] : sum[WIDTH];
        res_data  = kind == KIND_ALU ? alu_res : '0;
        push_data = {in_dest, res_data, kind == KIND_ALU, kind == KIND_CMP && cmp};
        accept    = in_valid & in_ready & ~flush;
        carry_d   = (accept && carry_upd) ? carry_new : carry_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) carry_q <= 1'b0;
        else        carry_q <= carry_d;
    end

    exec_alu_stage_skid_buf #(.DW(DW)) u_buf (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .push      (accept),
        .pop       (out_valid & out_ready),
        .push_data (push_data),
        .out_valid (out_valid),
        .head_data (head_data),
        .not_full  (in_ready)
    );

    assign {out_dest, out_data, out_wr_en, out_br_taken} = head_data;
    assign carry = carry_q;

endmodule
